mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory-side responder for the byte-serial memory protocol used by the pipeline initiators. Arbitrates between the instruction-fetch (IF) port and the MEM-stage port.
- Drives one single-port synchronous byte RAM and decodes a small IO window.
- Routes read bytes back to the port that issued them, with fixed one-cycle read latency and one byte per cycle when pipelined.

Parameters:
- ADDR_W, 32, byte address width on all ports
- IO_BASE, 32'h0003_0000, first address of the IO window; addresses >= IO_BASE never reach the RAM
- IO_TX_OFS, 4, offset of the IO transmit/halt byte register

Ports:
- clk  in  1  clock; one clock domain, all logic on posedge
- rst  in  1  reset; one clock; reset is synchronous and active-low
- if_req_i  in  1  IF port requests bus ownership
- if_addr_i  in  ADDR_W  IF byte address
- if_gnt_o  out  1  IF port owns the bus this cycle
- if_data_o  out  8  read byte returned to IF
- mem_req_i  in  1  MEM port requests bus ownership
- mem_addr_i  in  ADDR_W  MEM byte address
- mem_wr_i  in  1  MEM byte write strobe
- mem_wdata_i  in  8  MEM write byte
- mem_gnt_o  out  1  MEM port owns the bus this cycle
- mem_data_o  out  8  read byte returned to MEM
- ram_addr_o  out  ADDR_W  RAM address
- ram_wr_o  out  1  RAM write enable
- ram_wdata_o  out  8  RAM write byte
- ram_rdata_i  in  8  RAM read byte, valid the cycle after its address
- io_rx_i  in  8  IO receive byte, read at IO_BASE
- io_tx_o  out  8  last byte written to IO_BASE+IO_TX_OFS
- io_tx_valid_o  out  1  one-cycle pulse per IO transmit write

Behaviour:
- Owner FSM states: IDLE, OWN_IF, OWN_MEM. if_gnt_o = (state==OWN_IF); mem_gnt_o = (state==OWN_MEM). Both are registered.
- IDLE transitions: mem_req -> OWN_MEM; else if_req -> OWN_IF. On a simultaneous request, MEM wins.
- OWN_x transitions: stay while x_req is high; there is no preemption. When x_req drops, hand off at the same edge to the other port if it is requesting (no bubble); otherwise go to IDLE.
- Request phase: a port's address and write strobe are honoured only in cycles where its gnt is high. Initiators hold req high and wait for gnt before presenting the first address.
- RAM drive: combinational from the owner. In IDLE, and for any IO-window address, ram_wr_o = 0 and ram_addr_o = 0. IF is read-only, so ram_wr_o is never set on IF's behalf.
- Read return: a cycle-N read by owner P is captured in rd_owner/rd_io registers at edge N. During cycle N+1 the byte appears on P's data output: ram_rdata_i, or the io_rx_i value sampled at edge N for an IO read.
- The non-addressed data output holds its last returned value. Both data outputs reset to 0.
- Handoff does not disturb an in-flight return: a byte for the old owner is still delivered in the first cycle of the new owner.
- IO write: a MEM write to IO_BASE+IO_TX_OFS latches mem_wdata_i into io_tx_o and pulses io_tx_valid_o for exactly one cycle (registered). Other IO-window writes are dropped. Back-to-back writes give back-to-back pulses.
- IO read: a read at IO_BASE returns io_rx_i. Other IO-window reads return 8'h00.
- Reset (rst=0 at an edge), including mid-transfer:
  - state=IDLE; both gnt outputs 0; rd_owner cleared.
  - if_data_o, mem_data_o, io_tx_o = 0; io_tx_valid_o = 0.
  - ram_wr_o is 0 combinationally while rst is low.
  - No pending return byte is delivered after reset.
- Address arithmetic is unsigned. The IO decode compares the full ADDR_W.

Decomposition:
- Shared package: owner encoding (OWN_NONE/OWN_IF/OWN_MEM), IO_BASE and IO_TX_OFS defaults, byte-bus width constant. These are shared with the IF and MEM initiators.
- One natural sub-module: mem_arb, holding the owner FSM and gnt generation. Routing, IO decode and return logic stay in mem_ctrl.

Test Plan:
- Single IF read: if_req=1 at cycle 0. if_gnt=1 from cycle 1. Present 0x100 in cycle 1, with RAM[0x100]=0xA5. Required: if_data_o=0xA5 in cycle 2; ram_wr_o stays 0.
- MEM word write, 4 bytes back-to-back at 0x200..0x203 with 0x11,0x22,0x33,0x44. Then a 4-byte read. Required: ram_wr_o high 4 cycles; reads return 0x11,0x22,0x33,0x44 on consecutive cycles, each one cycle after its address.
- Simultaneous if_req and mem_req in IDLE: mem_gnt first, if_gnt=0 throughout MEM ownership. When mem_req drops, if_gnt rises on the very next cycle with no idle cycle. The last MEM read byte still lands on mem_data_o.
- IO: MEM writes 0x41 to 0x30004 -> io_tx_o=0x41 and io_tx_valid_o high exactly 1 cycle. MEM read of 0x30000 with io_rx_i=0x7E -> mem_data_o=0x7E next cycle; ram_wr_o=0 and ram_addr_o=0 throughout.
- Reset mid-transfer: assert rst=0 during the third byte of a MEM write. Required: next cycle both gnts 0, ram_wr_o 0, data outputs 0, no io pulse. After release, an IF request is granted normally.
- Ungranted activity: if_req=0 while the IF port drives an address and MEM writes with gnt low. Required: ram_wr_o=0 and no data returned to either port.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory protocol: owner encoding, IO window defaults
// and byte-bus width, common to mem_ctrl and the IF/MEM initiators.
package mem_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [31:0] IO_BASE_DEF   = 32'h0003_0000;
    localparam logic [31:0] IO_TX_OFS_DEF = 32'd4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arb.sv
// Bus-ownership arbiter: MEM wins ties from idle, owners keep the bus while requesting,
// and a dropped request hands off directly to a waiting port without an idle cycle.
module mem_arb
    import mem_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   if_req_i,
    input  logic   mem_req_i,
    output owner_e owner_o,
    output logic   if_gnt_o,
    output logic   mem_gnt_o
);

    owner_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OWN_NONE: begin
                if (mem_req_i)     state_d = OWN_MEM;
                else if (if_req_i) state_d = OWN_IF;
            end
            OWN_IF: begin
                if (!if_req_i) state_d = mem_req_i ? OWN_MEM : OWN_NONE;
            end
            OWN_MEM: begin
                if (!mem_req_i) state_d = if_req_i ? OWN_IF : OWN_NONE;
            end
            default: state_d = OWN_NONE;
        endcase
    end

    assign owner_o   = state_q;
    assign if_gnt_o  = (state_q == OWN_IF);
    assign mem_gnt_o = (state_q == OWN_MEM);

endmodule

// File: rtl/mem_ctrl.sv
// Memory-side responder: routes the owning port to a synchronous byte RAM or the IO window,
// and steers each read byte back to the port that issued it one cycle later.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] IO_BASE   = ADDR_W'(IO_BASE_DEF),
    parameter logic [ADDR_W-1:0] IO_TX_OFS = ADDR_W'(IO_TX_OFS_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic [BYTE_W-1:0] if_data_o,
    input  logic              mem_req_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic              mem_wr_i,
    input  logic [BYTE_W-1:0] mem_wdata_i,
    output logic              mem_gnt_o,
    output logic [BYTE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic [BYTE_W-1:0] ram_wdata_o,
    input  logic [BYTE_W-1:0] ram_rdata_i,
    input  logic [BYTE_W-1:0] io_rx_i,
    output logic [BYTE_W-1:0] io_tx_o,
    output logic              io_tx_valid_o
);

    localparam logic [ADDR_W-1:0] IO_TX_ADDR = IO_BASE + IO_TX_OFS;

    owner_e            owner;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wr, owned, is_io, rd_en, io_tx_hit;
    logic [BYTE_W-1:0] ret_byte;

    owner_e            rd_owner_q;
    logic              rd_io_q, io_tx_valid_q;
    logic [BYTE_W-1:0] rd_io_data_q, if_data_q, mem_data_q, io_tx_q;

    mem_arb u_arb (
        .clk       (clk),
        .rst       (rst),
        .if_req_i  (if_req_i),
        .mem_req_i (mem_req_i),
        .owner_o   (owner),
        .if_gnt_o  (if_gnt_o),
        .mem_gnt_o (mem_gnt_o)
    );

    // Only the owner's address/strobe are seen; IF can never write.
    always_comb begin
        req_addr = '0;
        req_wr   = 1'b0;
        case (owner)
            OWN_IF:  req_addr = if_addr_i;
            OWN_MEM: begin
                req_addr = mem_addr_i;
                req_wr   = mem_wr_i;
            end
            default: ;
        endcase
    end

    assign owned     = (owner != OWN_NONE);
    assign is_io     = (req_addr >= IO_BASE);
    assign rd_en     = owned && !req_wr;
    assign io_tx_hit = owned && req_wr && (req_addr == IO_TX_ADDR);

    assign ram_addr_o  = (owned && !is_io) ? req_addr : '0;
    assign ram_wr_o    = rst && owned && req_wr && !is_io;
    assign ram_wdata_o = mem_wdata_i;

    assign ret_byte   = rd_io_q ? rd_io_data_q : ram_rdata_i;
    assign if_data_o  = (rd_owner_q == OWN_IF)  ? ret_byte : if_data_q;
    assign mem_data_o = (rd_owner_q == OWN_MEM) ? ret_byte : mem_data_q;

    assign io_tx_o       = io_tx_q;
    assign io_tx_valid_o = io_tx_valid_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_owner_q    <= OWN_NONE;
            rd_io_q       <= 1'b0;
            rd_io_data_q  <= '0;
            if_data_q     <= '0;
            mem_data_q    <= '0;
            io_tx_q       <= '0;
            io_tx_valid_q <= 1'b0;
        end else begin
            rd_owner_q    <= rd_en ? owner : OWN_NONE;
            rd_io_q       <= is_io;
            // io_rx is sampled with the address so the byte matches the request cycle.
            rd_io_data_q  <= (req_addr == IO_BASE) ? io_rx_i : '0;
            // Hold the byte being delivered this cycle so it persists once the return ends.
            if (rd_owner_q == OWN_IF)  if_data_q  <= ret_byte;
            if (rd_owner_q == OWN_MEM) mem_data_q <= ret_byte;
            io_tx_valid_q <= io_tx_hit;
            if (io_tx_hit) io_tx_q <= mem_wdata_i;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed transfers push expected read bytes tagged with the
// cycle they must appear in; a negedge monitor pops and compares them against the data ports.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_wr, if_gnt_o, mem_gnt_o, ram_wr_o, io_tx_valid_o;
    logic [31:0] if_addr, mem_addr, ram_addr_o;
    logic [7:0]  mem_wdata, if_data_o, mem_data_o, ram_wdata_o, ram_rdata, io_rx, io_tx_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int         cyc;
        bit         port;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];

    mem_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_i      (if_req),
        .if_addr_i     (if_addr),
        .if_gnt_o      (if_gnt_o),
        .if_data_o     (if_data_o),
        .mem_req_i     (mem_req),
        .mem_addr_i    (mem_addr),
        .mem_wr_i      (mem_wr),
        .mem_wdata_i   (mem_wdata),
        .mem_gnt_o     (mem_gnt_o),
        .mem_data_o    (mem_data_o),
        .ram_addr_o    (ram_addr_o),
        .ram_wr_o      (ram_wr_o),
        .ram_wdata_o   (ram_wdata_o),
        .ram_rdata_i   (ram_rdata),
        .io_rx_i       (io_rx),
        .io_tx_o       (io_tx_o),
        .io_tx_valid_o (io_tx_valid_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous byte RAM: read-before-write, data valid the cycle after the address.
    logic [7:0] ram [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'hA5;
        forever begin
            @(posedge clk);
            ram_rdata <= ram[ram_addr_o[11:0]];
            if (ram_wr_o) ram[ram_addr_o[11:0]] = ram_wdata_o;
        end
    end

    // Monitor: every expected return is due in exactly one cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t       e;
            logic [7:0] got;
            e   = q.pop_front();
            got = e.port ? mem_data_o : if_data_o;
            vectors++;
            if (e.cyc != cyc || got !== e.data) begin
                miscompares++;
                $display("FAIL %s_return: cycle %0d got %02h, expected %02h due cycle %0d",
                         e.port ? "mem" : "if", cyc, got, e.data, e.cyc);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input bit port, input logic [7:0] data);
        exp_t e;
        e.cyc  = cyc + 1;
        e.port = port;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic wait_gnt(input bit m);
        for (int i = 0; i < 8; i++) begin
            if (m ? mem_gnt_o : if_gnt_o) break;
            step();
        end
        check(m ? "mem_gnt_wait" : "if_gnt_wait", m ? mem_gnt_o : if_gnt_o, 1);
    endtask

    task automatic mem_op(input logic [31:0] a, input logic wr, input logic [7:0] wd,
                          input logic last, input logic [7:0] exp_rd);
        mem_addr  = a;
        mem_wr    = wr;
        mem_wdata = wd;
        if (last) mem_req = 1'b0;
        if (!wr) expect_rd(1'b1, exp_rd);
        #1;
        check("mem_gnt_held", mem_gnt_o, 1);
        check("if_gnt_excl", if_gnt_o, 0);
        if (a >= 32'h0003_0000) begin
            check("io_ram_addr", ram_addr_o, 0);
            check("io_ram_wr", ram_wr_o, 0);
        end else begin
            check("mem_ram_addr", ram_addr_o, a);
            check("mem_ram_wr", ram_wr_o, wr);
        end
        step();
    endtask

    task automatic if_op(input logic [31:0] a, input logic last, input logic [7:0] exp_rd);
        if_addr = a;
        if (last) if_req = 1'b0;
        expect_rd(1'b0, exp_rd);
        #1;
        check("if_gnt_held", if_gnt_o, 1);
        check("mem_gnt_excl", mem_gnt_o, 0);
        check("if_ram_addr", ram_addr_o, a);
        check("if_ram_wr", ram_wr_o, 0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; if_req = 0; mem_req = 0; mem_wr = 0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0; io_rx = '0;
        step(); step(); step();
        check("rst_if_gnt", if_gnt_o, 0);
        check("rst_mem_gnt", mem_gnt_o, 0);
        check("rst_if_data", if_data_o, 0);
        check("rst_mem_data", mem_data_o, 0);
        check("rst_io_valid", io_tx_valid_o, 0);
        rst = 1'b1;
        step();

        // Single IF read
        if_req = 1'b1;
        step();
        check("if_gnt_c1", if_gnt_o, 1);
        if_op(32'h100, 1'b1, 8'hA5);
        check("if_idle_ram_wr", ram_wr_o, 0);

        // MEM 4-byte write then pipelined 4-byte read
        mem_req = 1'b1;
        step();
        wait_gnt(1'b1);
        mem_op(32'h200, 1'b1, 8'h11, 1'b0, 8'h00);
        mem_op(32'h201, 1'b1, 8'h22, 1'b0, 8'h00);
        mem_op(32'h202, 1'b1, 8'h33, 1'b0, 8'h00);
        mem_op(32'h203, 1'b1, 8'h44, 1'b0, 8'h00);
        mem_op(32'h200, 1'b0, 8'h00, 1'b0, 8'h11);
        mem_op(32'h201, 1'b0, 8'h00, 1'b0, 8'h22);
        mem_op(32'h202, 1'b0, 8'h00, 1'b0, 8'h33);
        mem_op(32'h203, 1'b0, 8'h00, 1'b1, 8'h44);
        check("idle_ram_wr", ram_wr_o, 0);

        // Simultaneous requests: MEM first, then IF with no bubble
        if_req = 1'b1; mem_req = 1'b1;
        step();
        check("tie_mem_gnt", mem_gnt_o, 1);
        mem_op(32'h200, 1'b0, 8'h00, 1'b0, 8'h11);
        mem_op(32'h201, 1'b0, 8'h00, 1'b1, 8'h22);
        check("handoff_if_gnt", if_gnt_o, 1);
        if_op(32'h100, 1'b1, 8'hA5);

        // IO window
        mem_req = 1'b1;
        step();
        wait_gnt(1'b1);
        mem_op(32'h0003_0004, 1'b1, 8'h41, 1'b0, 8'h00);
        check("io_tx_valid_pulse", io_tx_valid_o, 1);
        check("io_tx_byte", io_tx_o, 8'h41);
        io_rx = 8'h7E;
        mem_op(32'h0003_0008, 1'b0, 8'h00, 1'b0, 8'h00);
        check("io_tx_valid_once", io_tx_valid_o, 0);
        mem_op(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h7E);
        check("io_tx_hold", io_tx_o, 8'h41);

        // Ungranted activity
        if_addr = 32'h100; mem_addr = 32'h200; mem_wr = 1'b1; mem_wdata = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ungr_ram_wr", ram_wr_o, 0);
            check("ungr_if_data_hold", if_data_o, 8'hA5);
            check("ungr_mem_data_hold", mem_data_o, 8'h7E);
        end
        if_req = 1'b1;
        step();
        wait_gnt(1'b0);
        if_op(32'h200, 1'b1, 8'h11);
        mem_wr = 1'b0;

        // Reset during the third byte of a MEM write
        mem_req = 1'b1;
        step();
        wait_gnt(1'b1);
        mem_op(32'h300, 1'b1, 8'h55, 1'b0, 8'h00);
        mem_op(32'h301, 1'b1, 8'h66, 1'b0, 8'h00);
        mem_addr = 32'h302; mem_wr = 1'b1; mem_wdata = 8'h77; rst = 1'b0;
        #1;
        check("rst_low_ram_wr", ram_wr_o, 0);
        step();
        check("rst_mid_if_gnt", if_gnt_o, 0);
        check("rst_mid_mem_gnt", mem_gnt_o, 0);
        check("rst_mid_ram_wr", ram_wr_o, 0);
        check("rst_mid_if_data", if_data_o, 0);
        check("rst_mid_mem_data", mem_data_o, 0);
        check("rst_mid_io_valid", io_tx_valid_o, 0);
        check("rst_mid_io_tx", io_tx_o, 0);
        rst = 1'b1; mem_req = 1'b0; mem_wr = 1'b0;
        step();
        check("post_rst_mem_data", mem_data_o, 0);
        check("post_rst_mem_gnt", mem_gnt_o, 0);
        if_req = 1'b1;
        step();
        wait_gnt(1'b0);
        if_op(32'h301, 1'b0, 8'h66);
        if_op(32'h302, 1'b1, 8'h00);

        step(); step();
        check("queue_drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
